// File: rtl/uart_rx_history.sv
// uart_rx_history: drains a UART receive FIFO one word at a time and keeps a
// shift history of the last DEPTH words, exposed flat for displays/debug.
// Freeze either stalls FIFO reads or keeps reading and discards the data.
// Synchronous clear wipes history and counters. Counters track accepted and
// discarded words.
//
// FIFO handshake: the FIFO head (rx_data) is valid whenever rx_empty=0. The
// block raises rd_uart for exactly one clock per word. The FIFO pops at the
// end of that clock. The block never samples rx_empty in the clock right
// after a pop, so a stale empty flag cannot cause a double read.
//
// DEPTH is intended for the range 2..16.
module uart_rx_history #(
    parameter int DATA_W           = 8,
    parameter int DEPTH            = 4,
    parameter int CNT_W            = 16,
    parameter int DROP_WHEN_FROZEN = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            rx_data,
    input  logic                         rx_empty,
    output logic                         rd_uart,
    input  logic                         freeze,
    input  logic                         clear,
    output logic [DEPTH*DATA_W-1:0]      hist_out,
    output logic [$clog2(DEPTH+1)-1:0]   valid_cnt,
    output logic [CNT_W-1:0]             byte_cnt,
    output logic [CNT_W-1:0]             drop_cnt,
    output logic                         new_byte,
    output logic                         led0
);

    localparam int                 VALID_W   = $clog2(DEPTH + 1);
    localparam logic [VALID_W-1:0] VALID_MAX = VALID_W'(DEPTH);
    localparam logic [CNT_W-1:0]   DROP_MAX  = {CNT_W{1'b1}};
    localparam logic               DROP_EN   = (DROP_WHEN_FROZEN != 0);

    // Two-state read sequencer: IDLE may start a read, POP is the strobe cycle.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_POP  = 1'b1;

    logic [0:0]        r_state;
    logic              r_rd_uart;
    logic              r_new_byte;
    logic [DATA_W-1:0] r_hist [DEPTH];
    logic [VALID_W-1:0] r_valid_cnt;
    logic [CNT_W-1:0]  r_byte_cnt;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic w_go;
    logic w_accept;
    logic w_drop;

    // A read starts only from IDLE. Clear blocks it. Freeze blocks it
    // unless this instance discards words while frozen.
    assign w_go     = (r_state == ST_IDLE) & ~rx_empty & ~clear & (~freeze | DROP_EN);
    assign w_accept = w_go & ~freeze;
    assign w_drop   = w_go & freeze;

    // Sequencer, read strobe and new-word pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_rd_uart  <= 1'b0;
            r_new_byte <= 1'b0;
        end else begin
            r_new_byte <= w_accept;
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_state   <= ST_POP;
                        r_rd_uart <= 1'b1;
                    end else begin
                        r_rd_uart <= 1'b0;
                    end
                end
                default: begin
                    // The FIFO pops at the end of this cycle; always go back.
                    r_state   <= ST_IDLE;
                    r_rd_uart <= 1'b0;
                end
            endcase
        end
    end

    // History shift register: slot 0 newest, the oldest slot falls off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) r_hist[k] <= '0;
        end else if (clear) begin
            for (int k = 0; k < DEPTH; k++) r_hist[k] <= '0;
        end else if (w_accept) begin
            for (int k = DEPTH - 1; k > 0; k--) r_hist[k] <= r_hist[k-1];
            r_hist[0] <= rx_data;
        end
    end

    // Fill level, saturating at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid_cnt <= '0;
        end else if (clear) begin
            r_valid_cnt <= '0;
        end else if (w_accept && (r_valid_cnt != VALID_MAX)) begin
            r_valid_cnt <= r_valid_cnt + VALID_W'(1);
        end
    end

    // Accepted-word counter, wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byte_cnt <= '0;
        end else if (clear) begin
            r_byte_cnt <= '0;
        end else if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
        end
    end

    // Discarded-word counter, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (clear) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != DROP_MAX)) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end

    // Flatten the history array onto the output bus.
    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign hist_out[g*DATA_W +: DATA_W] = r_hist[g];
    end

    assign rd_uart   = r_rd_uart;
    assign new_byte  = r_new_byte;
    assign valid_cnt = r_valid_cnt;
    assign byte_cnt  = r_byte_cnt;
    assign drop_cnt  = r_drop_cnt;
    assign led0      = rx_empty;

endmodule

// File: tb/tb_uart_rx_history.sv
// Bench for uart_rx_history: one stall-mode instance (index 0) and one
// drop-mode instance (index 1) share reset/freeze/clear. Each instance has
// its own FIFO model. A behavioural history model predicts every output on
// every cycle. Directed literal checks pin the model at key points.
module tb_uart_rx_history;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 16;
    localparam int VW    = $clog2(DEPTH + 1);
    localparam int FSZ   = 64;

    logic clk = 1'b0;
    logic reset;
    logic freeze;
    logic clear;
    logic [1:0]          rx_empty;
    logic [1:0][DW-1:0]  rx_data;

    wire [1:0]               rd_uart;
    wire [1:0]               new_byte;
    wire [1:0]               led0;
    wire [1:0][DEPTH*DW-1:0] hist_out;
    wire [1:0][VW-1:0]       valid_cnt;
    wire [1:0][CW-1:0]       byte_cnt;
    wire [1:0][CW-1:0]       drop_cnt;

    always #5 clk = ~clk;

    uart_rx_history #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW), .DROP_WHEN_FROZEN(0)) u_stall (
        .clk(clk), .reset(reset), .rx_data(rx_data[0]), .rx_empty(rx_empty[0]),
        .rd_uart(rd_uart[0]), .freeze(freeze), .clear(clear), .hist_out(hist_out[0]),
        .valid_cnt(valid_cnt[0]), .byte_cnt(byte_cnt[0]), .drop_cnt(drop_cnt[0]),
        .new_byte(new_byte[0]), .led0(led0[0])
    );

    uart_rx_history #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW), .DROP_WHEN_FROZEN(1)) u_drop (
        .clk(clk), .reset(reset), .rx_data(rx_data[1]), .rx_empty(rx_empty[1]),
        .rd_uart(rd_uart[1]), .freeze(freeze), .clear(clear), .hist_out(hist_out[1]),
        .valid_cnt(valid_cnt[1]), .byte_cnt(byte_cnt[1]), .drop_cnt(drop_cnt[1]),
        .new_byte(new_byte[1]), .led0(led0[1])
    );

    // FIFO models
    logic [DW-1:0] fmem [2][FSZ];
    int fhead [2];
    int ftail [2];

    // Behavioural model: newest-first word list plus counters
    logic [DW-1:0] m_hist [2][DEPTH];
    int            m_fill [2];
    logic [CW-1:0] m_byte [2];
    logic [CW-1:0] m_drop [2];
    logic          m_rd   [2];
    logic          m_nb   [2];

    int n_checks = 0;
    int n_pass   = 0;
    int pulses [2];
    int p0, p1;

    task automatic check(input string name, input int i, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h expected %h", name, i, act, exp);
    endtask

    function automatic logic [DEPTH*DW-1:0] exp_hist(input int i);
        logic [DEPTH*DW-1:0] h;
        h = '0;
        for (int k = 0; k < DEPTH; k++) h[k*DW +: DW] = m_hist[i][k];
        return h;
    endfunction

    task automatic refresh_rx();
        for (int i = 0; i < 2; i++) begin
            rx_empty[i] = (fhead[i] == ftail[i]);
            rx_data[i]  = rx_empty[i] ? '0 : fmem[i][fhead[i] % FSZ];
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        for (int i = 0; i < 2; i++) begin
            fmem[i][ftail[i] % FSZ] = d;
            ftail[i]++;
        end
        refresh_rx();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < DEPTH; k++) m_hist[i][k] = '0;
            m_fill[i] = 0;
            m_byte[i] = '0;
            m_drop[i] = '0;
            m_rd[i]   = 1'b0;
            m_nb[i]   = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            fhead[i] = 0;
            ftail[i] = 0;
        end
        refresh_rx();
    endtask

    // One clock edge of the specified behaviour: a read may start only if
    // none started on the previous edge.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic start;
            logic acc;
            start = !m_rd[i] && !rx_empty[i] && !clear && (!freeze || (i == 1));
            acc   = start && !freeze;
            m_rd[i] = start;
            m_nb[i] = acc;
            if (clear) begin
                for (int k = 0; k < DEPTH; k++) m_hist[i][k] = '0;
                m_fill[i] = 0;
                m_byte[i] = '0;
                m_drop[i] = '0;
            end else if (acc) begin
                for (int k = DEPTH - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
                m_hist[i][0] = rx_data[i];
                if (m_fill[i] < DEPTH) m_fill[i]++;
                m_byte[i] = m_byte[i] + 1'b1;
            end else if (start && (m_drop[i] != {CW{1'b1}})) begin
                m_drop[i] = m_drop[i] + 1'b1;
            end
        end
    endtask

    // Advance one clock: model on the edge, FIFO pop just after, then
    // compare every output on the falling edge.
    task automatic tick();
        logic [1:0] pop;
        @(posedge clk);
        pop = rd_uart;
        if (!reset) model_step();
        #1;
        for (int i = 0; i < 2; i++)
            if (pop[i] && (fhead[i] != ftail[i])) fhead[i]++;
        refresh_rx();
        #4;
        for (int i = 0; i < 2; i++) begin
            check("cycle", i,
                  128'({rd_uart[i], new_byte[i], led0[i], hist_out[i], valid_cnt[i], byte_cnt[i], drop_cnt[i]}),
                  128'({m_rd[i], m_nb[i], rx_empty[i], exp_hist(i), VW'(m_fill[i]), m_byte[i], m_drop[i]}));
            pulses[i] += int'(rd_uart[i]);
        end
    endtask

    initial begin
        freeze = 1'b0;
        clear  = 1'b0;
        pulses[0] = 0;
        pulses[1] = 0;
        do_reset();
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            check("rst_rd", i, 128'(rd_uart[i]), 128'(0));
            check("rst_hist", i, 128'(hist_out[i]), 128'(0));
            check("rst_cnt", i, 128'({valid_cnt[i], byte_cnt[i], drop_cnt[i]}), 128'(0));
        end
        reset = 1'b0;
        repeat (2) tick();

        // Five words into a four-deep history
        p0 = pulses[0];
        push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
        repeat (12) tick();
        check("five_pops", 0, 128'(pulses[0] - p0), 128'(5));
        for (int i = 0; i < 2; i++) begin
            check("five_hist", i, 128'(hist_out[i]), 128'(32'h2233_4455));
            check("five_valid", i, 128'(valid_cnt[i]), 128'(4));
            check("five_bytes", i, 128'(byte_cnt[i]), 128'(5));
        end

        // FIFO kept non-empty for 20 clocks
        p0 = pulses[0];
        for (int w = 1; w <= 12; w++) push(8'(w));
        repeat (20) tick();
        check("burst_pops", 0, 128'(pulses[0] - p0), 128'(10));
        repeat (6) tick();
        for (int i = 0; i < 2; i++) begin
            check("burst_hist", i, 128'(hist_out[i]), 128'(32'h090A_0B0C));
            check("burst_bytes", i, 128'(byte_cnt[i]), 128'(17));
        end

        // Freeze with three words queued
        freeze = 1'b1;
        p0 = pulses[0];
        p1 = pulses[1];
        push(8'hC1); push(8'hC2); push(8'hC3);
        repeat (10) tick();
        check("frz_pops", 0, 128'(pulses[0] - p0), 128'(0));
        check("frz_pops", 1, 128'(pulses[1] - p1), 128'(3));
        check("frz_drop", 1, 128'(drop_cnt[1]), 128'(3));
        for (int i = 0; i < 2; i++) begin
            check("frz_hist", i, 128'(hist_out[i]), 128'(32'h090A_0B0C));
            check("frz_bytes", i, 128'(byte_cnt[i]), 128'(17));
        end
        freeze = 1'b0;
        repeat (10) tick();
        check("thaw_pops", 0, 128'(pulses[0] - p0), 128'(3));
        check("thaw_hist", 0, 128'(hist_out[0]), 128'(32'h0CC1_C2C3));
        check("thaw_bytes", 0, 128'(byte_cnt[0]), 128'(20));
        check("thaw_hist", 1, 128'(hist_out[1]), 128'(32'h090A_0B0C));

        // Drop mode: 0xAA, 0xBB discarded while frozen
        freeze = 1'b1;
        push(8'hAA); push(8'hBB);
        repeat (8) tick();
        check("drop_cnt", 1, 128'(drop_cnt[1]), 128'(5));
        check("drop_bytes", 1, 128'(byte_cnt[1]), 128'(17));
        check("drop_hist", 1, 128'(hist_out[1]), 128'(32'h090A_0B0C));

        // Clear together with freeze: clear wins
        clear = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 2; i++)
            check("clr_all", i, 128'({hist_out[i], valid_cnt[i], byte_cnt[i], drop_cnt[i]}), 128'(0));
        clear  = 1'b0;
        freeze = 1'b0;
        repeat (6) tick();
        check("post_clr_hist", 0, 128'(hist_out[0]), 128'(32'h0000_AABB));
        check("post_clr_valid", 0, 128'(valid_cnt[0]), 128'(2));
        check("post_clr_bytes", 0, 128'(byte_cnt[0]), 128'(2));

        // Clear during the POP cycle of 0x5A
        p0 = pulses[0];
        p1 = pulses[1];
        push(8'h5A);
        tick();
        check("pop5a_rd", 0, 128'(rd_uart[0]), 128'(1));
        check("pop5a_bytes", 0, 128'(byte_cnt[0]), 128'(3));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 2; i++)
            check("clr_pop", i, 128'({rd_uart[i], hist_out[i], valid_cnt[i], byte_cnt[i]}), 128'(0));
        repeat (4) tick();
        check("clr_pop_pulses", 0, 128'(pulses[0] - p0), 128'(1));
        check("clr_pop_pulses", 1, 128'(pulses[1] - p1), 128'(1));

        // Asynchronous reset in the middle of a POP cycle
        push(8'h77);
        tick();
        check("pre_rst_rd", 0, 128'(rd_uart[0]), 128'(1));
        do_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            check("async_rst", i,
                  128'({rd_uart[i], new_byte[i], hist_out[i], valid_cnt[i], byte_cnt[i], drop_cnt[i]}), 128'(0));
            check("async_led0", i, 128'(led0[i]), 128'(1));
        end
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        push(8'h12);
        #1;
        check("led0_live", 0, 128'(led0[0]), 128'(0));
        repeat (4) tick();
        check("after_rst_hist", 0, 128'(hist_out[0]), 128'(32'h0000_0012));
        check("after_rst_led0", 0, 128'(led0[0]), 128'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_history.md
Name: uart_rx_history

Overview:
- Parametrised successor to the single current/previous UART receive-byte capture stage.
- Drains the UART receiver FIFO with a strict one-pulse-per-byte read handshake.
- Keeps a shift history of the last DEPTH words and exposes it flat for hex displays or debug.
- Adds freeze (stall or drop mode), synchronous clear, fill level, a received-byte counter and a drop counter.

Parameters:
- DATA_W, 8, width of one received word.
- DEPTH, 4, number of history slots; legal range 2..16.
- CNT_W, 16, width of byte_cnt and drop_cnt.
- DROP_WHEN_FROZEN, 0; 0 = freeze stalls FIFO reads, 1 = freeze keeps reading and discards data.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  DATA_W  FIFO head word; valid whenever rx_empty=0.
- rx_empty  in  1  FIFO empty flag.
- rd_uart  out  1  FIFO pop strobe; one cycle per word.
- freeze  in  1  hold history contents (level).
- clear  in  1  synchronous clear of history and counters (level).
- hist_out  out  DEPTH*DATA_W  history; slot k = bits [k*DATA_W +: DATA_W]; slot 0 = newest.
- valid_cnt  out  $clog2(DEPTH+1)  number of filled slots.
- byte_cnt  out  CNT_W  words accepted into history.
- drop_cnt  out  CNT_W  words popped and discarded while frozen.
- new_byte  out  1  one-cycle pulse, coincident with the cycle hist_out first shows a new word.
- led0  out  1  equals rx_empty (combinational).

Behaviour:
- Reset (async, active-high) clears to 0: rd_uart, hist_out, valid_cnt, byte_cnt, drop_cnt, new_byte. FSM goes to IDLE.
- All outputs except led0 are registered.
- FSM has two states, IDLE and POP.
- IDLE, define go = ~rx_empty & ~clear & (~freeze | DROP_WHEN_FROZEN).
  - go=1: sample rx_data at this edge, set rd_uart<=1, go to POP.
  - If accepting (~freeze): shift hist (slot k <= slot k-1, slot 0 <= rx_data, oldest slot lost), new_byte<=1, byte_cnt+1, valid_cnt+1.
  - If dropping (freeze & DROP_WHEN_FROZEN): history unchanged, drop_cnt+1, new_byte stays 0.
  - go=0: stay in IDLE, rd_uart<=0.
- POP: rd_uart is high for exactly this cycle and the FIFO pops at the end of it. Set rd_uart<=0, new_byte<=0, return to IDLE unconditionally.
- Consequences of the FSM:
  - rx_empty is never sampled in the cycle it may still be stale after a pop, so there is no double read.
  - Maximum throughput is 1 word per 2 clocks.
  - Capture latency is 1 clock from IDLE with rx_empty=0 to hist_out/new_byte/rd_uart.
- Arithmetic:
  - valid_cnt saturates at DEPTH.
  - byte_cnt wraps modulo 2^CNT_W.
  - drop_cnt saturates at 2^CNT_W-1.
- freeze=1, DROP_WHEN_FROZEN=0: no reads are issued and the FIFO may fill; upstream overflow is the receiver's concern.
- freeze asserted while in POP: the in-flight pop completes normally and the word already captured stays in history.
- clear=1: hist_out, valid_cnt, byte_cnt and drop_cnt <= 0 next edge. Clear has priority over capture and drop, and no new read starts.
- clear=1 during POP: rd_uart still deasserts normally and the FIFO pop completes. The word captured on entry is erased; byte_cnt ends at 0, not 1.
- clear and freeze together: clear wins.
- reset mid-POP: rd_uart drops immediately (async). The FIFO sees a truncated strobe, which is acceptable because the system resets together.

Test Plan:
- Reset, then push 0x11,0x22,0x33,0x44,0x55 with DEPTH=4 → rd_uart pulses 5 times, each 1 cycle and ≥1 cycle apart; final hist_out slots 0..3 = 0x55,0x44,0x33,0x22; valid_cnt=4; byte_cnt=5.
- FIFO continuously non-empty for 20 clocks → rd_uart waveform 1,0,1,0…; exactly 10 pops; new_byte aligned with each hist_out change.
- DROP_WHEN_FROZEN=0: freeze=1 with 3 words queued → rd_uart stays 0 and hist_out unchanged; release freeze → 3 pops and history updated in order.
- DROP_WHEN_FROZEN=1: freeze=1, push 0xAA,0xBB → 2 pops; drop_cnt=2; hist_out unchanged; byte_cnt unchanged.
- clear asserted in the POP cycle of 0x5A → rd_uart still single-cycle; next cycle hist_out=0, byte_cnt=0, valid_cnt=0.
- Async reset asserted mid-POP → rd_uart, new_byte and counters go to 0 without waiting for a clock edge; led0 tracks rx_empty throughout.
